// File: rtl/equiv_pkg.sv
// Shared definitions for the equivalence stimulus generator: LFSR constants,
// DUT-input slice layout, run-state encoding and LFSR helper functions.
package equiv_pkg;

    localparam int          LFSR_W    = 64;
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

    localparam int W0_W   = 8;
    localparam int W1_W   = 4;
    localparam int W2_W   = 21;
    localparam int W3_W   = 19;
    localparam int W0_LSB = 0;
    localparam int W1_LSB = 8;
    localparam int W2_LSB = 12;
    localparam int W3_LSB = 33;
    localparam int VEC_W  = W0_W + W1_W + W2_W + W3_W;

    localparam int Y_W_DEF = 91;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Galois step: shift right, fold the polynomial in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_POLY;
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == 64'd0) ? 64'd1 : s;
    endfunction

endpackage

// File: rtl/equiv_stim_gen_if.sv
// Bundle between the stimulus generator and the two DUT variants it feeds and checks.
interface equiv_stim_gen_if import equiv_pkg::*; #(
    parameter int Y_W = Y_W_DEF
);
    logic                   start;
    logic signed [W0_W-1:0] wire0;
    logic signed [W1_W-1:0] wire1;
    logic        [W2_W-1:0] wire2;
    logic        [W3_W-1:0] wire3;
    logic        [Y_W-1:0]  y_1;
    logic        [Y_W-1:0]  y_2;
    logic                   busy;
    logic                   done;
    logic                   mismatch;
    logic        [31:0]     fail_idx;
    logic        [31:0]     vec_cnt;

    modport master (
        input  start, y_1, y_2,
        output wire0, wire1, wire2, wire3, busy, done, mismatch, fail_idx, vec_cnt
    );

    modport slave (
        output start, y_1, y_2,
        input  wire0, wire1, wire2, wire3, busy, done, mismatch, fail_idx, vec_cnt
    );
endinterface

// File: rtl/equiv_lfsr64.sv
// 64-bit Galois LFSR with restart-from-seed and step controls; a zero seed is forced to 1.
module equiv_lfsr64 import equiv_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 64'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] RST_VAL = seed_fix(SEED);

    logic [LFSR_W-1:0] q_r;

    // Load jumps one step past the seed, since the seed itself goes straight onto the wires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (load) begin
            q_r <= lfsr_next(seed_fix(seed));
        end else if (advance) begin
            q_r <= lfsr_next(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/equiv_stim_gen.sv
// Equivalence harness stimulus/checker: drives LFSR vectors to two DUT variants,
// compares their outputs DUT_LAT cycles later and captures the first miscompare.
module equiv_stim_gen import equiv_pkg::*; #(
    parameter int          NUM_VEC = 1024,
    parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001,
    parameter int          DUT_LAT = 1,
    parameter int          Y_W     = Y_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    equiv_stim_gen_if.master bus
);

    localparam logic [LFSR_W-1:0] SEED_FIX   = seed_fix(SEED);
    localparam logic [31:0]       NUM_VEC_U  = 32'(NUM_VEC);
    localparam logic [3:0]        DRAIN_LAST = 4'(DUT_LAT);
    localparam int                PIPE_D     = (DUT_LAT == 0) ? 1 : DUT_LAT;

    state_e              state_r;
    state_e              next_s;
    logic                lfsr_load_s;
    logic                lfsr_adv_s;
    logic [LFSR_W-1:0]   lfsr_q_s;
    logic [VEC_W-1:0]    wires_r;
    logic [31:0]         vec_cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                mismatch_r;
    logic [31:0]         fail_idx_r;
    logic [3:0]          drain_cnt_r;
    logic                live_vld_s;
    logic [31:0]         live_idx_s;
    logic                pipe_vld_r [PIPE_D];
    logic [31:0]         pipe_idx_r [PIPE_D];
    logic                cmp_vld_s;
    logic [31:0]         cmp_idx_s;
    logic [Y_W-1:0]      y_diff_s;

    equiv_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load_s),
        .advance (lfsr_adv_s),
        .seed    (SEED),
        .q       (lfsr_q_s)
    );

    // Run state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and LFSR control; start is only honoured between runs.
    always_comb begin
        next_s      = state_r;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_s      = RUN;
                    lfsr_load_s = 1'b1;
                end else begin
                    next_s = state_r;
                end
            end
            RUN: begin
                if (vec_cnt_r < NUM_VEC_U) begin
                    next_s     = RUN;
                    lfsr_adv_s = 1'b1;
                end else begin
                    next_s = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    next_s = DONE;
                end else begin
                    next_s = DRAIN;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Drain counter: DRAIN holds until the last vector's compare edge has passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= 4'd0;
        end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + 4'd1;
        end else begin
            drain_cnt_r <= 4'd0;
        end
    end

    // The vector on the wires is valid whenever RUN is active; its index is vec_cnt-1.
    assign live_vld_s = (state_r == RUN);
    assign live_idx_s = vec_cnt_r - 32'd1;

    // Check pipeline: delays the valid/index tag to line up with the DUT outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_D; i++) begin
                pipe_vld_r[i] <= 1'b0;
                pipe_idx_r[i] <= 32'd0;
            end
        end else begin
            pipe_vld_r[0] <= live_vld_s;
            pipe_idx_r[0] <= live_idx_s;
            for (int i = 1; i < PIPE_D; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_idx_r[i] <= pipe_idx_r[i-1];
            end
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_cmp_live
            assign cmp_vld_s = live_vld_s;
            assign cmp_idx_s = live_idx_s;
        end else begin : g_cmp_pipe
            assign cmp_vld_s = pipe_vld_r[PIPE_D-1];
            assign cmp_idx_s = pipe_idx_r[PIPE_D-1];
        end
    endgenerate

    assign y_diff_s = bus.y_1 ^ bus.y_2;

    // Wires, vector counter, status flags and first-fail capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wires_r    <= {VEC_W{1'b0}};
            vec_cnt_r  <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mismatch_r <= 1'b0;
            fail_idx_r <= 32'd0;
        end else begin
            if (lfsr_load_s) begin
                wires_r   <= SEED_FIX[VEC_W-1:0];
                vec_cnt_r <= 32'd1;
            end else if (lfsr_adv_s) begin
                wires_r   <= lfsr_q_s[VEC_W-1:0];
                vec_cnt_r <= vec_cnt_r + 32'd1;
            end else begin
                wires_r   <= wires_r;
                vec_cnt_r <= vec_cnt_r;
            end

            busy_r <= (next_s == RUN) || (next_s == DRAIN);
            done_r <= (next_s == DONE);

            if (lfsr_load_s) begin
                mismatch_r <= 1'b0;
                fail_idx_r <= 32'd0;
            end else if (cmp_vld_s && !mismatch_r && (y_diff_s != {Y_W{1'b0}})) begin
                mismatch_r <= 1'b1;
                fail_idx_r <= cmp_idx_s;
            end else begin
                mismatch_r <= mismatch_r;
                fail_idx_r <= fail_idx_r;
            end
        end
    end

    assign bus.wire0    = wires_r[W0_LSB +: W0_W];
    assign bus.wire1    = wires_r[W1_LSB +: W1_W];
    assign bus.wire2    = wires_r[W2_LSB +: W2_W];
    assign bus.wire3    = wires_r[W3_LSB +: W3_W];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.mismatch = mismatch_r;
    assign bus.fail_idx = fail_idx_r;
    assign bus.vec_cnt  = vec_cnt_r;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Self-checking bench for equiv_stim_gen: table-driven runs, reset abort/replay,
// randomized miscompare injection against a reference model, and latency corners.
module tb_equiv_stim_gen;
    import equiv_pkg::*;

    localparam int          YW     = 91;
    localparam int          NB     = 8;
    localparam int          LB     = 2;
    localparam logic [63:0] SEED_B = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] SEED_C = 64'h0;
    localparam logic [63:0] SEED_D = 64'hFFFF_0000_1234_5678;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    equiv_stim_gen_if #(.Y_W(YW)) ifa ();
    equiv_stim_gen_if #(.Y_W(YW)) ifb ();
    equiv_stim_gen_if #(.Y_W(YW)) ifc ();
    equiv_stim_gen_if #(.Y_W(YW)) ifd ();

    equiv_stim_gen #(.NUM_VEC(4),  .SEED(64'h1),  .DUT_LAT(1),  .Y_W(YW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    equiv_stim_gen #(.NUM_VEC(NB), .SEED(SEED_B), .DUT_LAT(LB), .Y_W(YW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    equiv_stim_gen #(.NUM_VEC(1),  .SEED(SEED_C), .DUT_LAT(0),  .Y_W(YW)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    equiv_stim_gen #(.NUM_VEC(1),  .SEED(SEED_D), .DUT_LAT(3),  .Y_W(YW)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    typedef struct {
        logic        start;
        logic        flip;
        logic [51:0] w;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
        logic        mm;
        logic [31:0] fidx;
    } row_t;

    row_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic f, input logic [51:0] w, input logic b,
                       input logic d, input int c, input logic m, input int fi);
        row_t r;
        r.start = s; r.flip = f; r.w = w; r.busy = b; r.done = d;
        r.cnt = 32'(c); r.mm = m; r.fidx = 32'(fi);
        tbl.push_back(r);
    endtask

    function automatic logic [63:0] step(input logic [63:0] s);
        logic [63:0] poly;
        poly = 64'hD800_0000_0000_0000;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    // Expected DUT-input vector k of a run, from the seed and the LFSR rule.
    function automatic logic [51:0] vec_of(input logic [63:0] seed, input int k);
        logic [63:0] s;
        s = (seed == 64'd0) ? 64'd1 : seed;
        for (int i = 0; i < k; i++) s = step(s);
        return s[51:0];
    endfunction

    function automatic logic [YW-1:0] rand_y();
        return {27'($urandom), $urandom, $urandom};
    endfunction

    logic [YW-1:0] yr;
    logic [YW-1:0] flip_one;

    initial begin
        flip_one = {{(YW-1){1'b0}}, 1'b1};
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
        ifa.y_1 = '0; ifa.y_2 = '0; ifb.y_1 = '0; ifb.y_2 = '0;
        ifc.y_1 = '0; ifc.y_2 = '0; ifd.y_1 = '0; ifd.y_2 = '0;

        // run 1 clean, run 2 with miscompares on vectors 2 and 3, run 3 with starts while busy
        add(1,0,52'h1,1,0,1,0,0); add(0,0,52'h0,1,0,2,0,0); add(0,0,52'h0,1,0,3,0,0);
        add(0,0,52'h0,1,0,4,0,0); add(0,0,52'h0,1,0,4,0,0); add(0,0,52'h0,1,0,4,0,0);
        add(0,0,52'h0,0,1,4,0,0);
        add(1,0,52'h1,1,0,1,0,0); add(0,0,52'h0,1,0,2,0,0); add(0,0,52'h0,1,0,3,0,0);
        add(0,0,52'h0,1,0,4,0,0); add(0,1,52'h0,1,0,4,1,2); add(0,1,52'h0,1,0,4,1,2);
        add(0,0,52'h0,0,1,4,1,2);
        add(1,0,52'h1,1,0,1,0,0); add(0,0,52'h0,1,0,2,0,0); add(1,0,52'h0,1,0,3,0,0);
        add(1,0,52'h0,1,0,4,0,0); add(0,0,52'h0,1,0,4,0,0); add(0,0,52'h0,1,0,4,0,0);
        add(0,0,52'h0,0,1,4,0,0);

        #23 rst_n = 1'b1;
        @(negedge clk);
        check("A_idle_busy", 64'(ifa.busy), 64'd0);
        check("A_idle_done", 64'(ifa.done), 64'd0);
        check("A_idle_wires", 64'({ifa.wire3, ifa.wire2, ifa.wire1, ifa.wire0}), 64'd0);

        foreach (tbl[i]) begin
            yr = rand_y();
            ifa.start = tbl[i].start;
            ifa.y_1   = yr;
            ifa.y_2   = tbl[i].flip ? (yr ^ flip_one) : yr;
            @(posedge clk);
            @(negedge clk);
            ifa.start = 1'b0;
            check("A_wires", 64'({ifa.wire3, ifa.wire2, ifa.wire1, ifa.wire0}), 64'(tbl[i].w));
            check("A_busy", 64'(ifa.busy), 64'(tbl[i].busy));
            check("A_done", 64'(ifa.done), 64'(tbl[i].done));
            check("A_vec_cnt", 64'(ifa.vec_cnt), 64'(tbl[i].cnt));
            check("A_mismatch", 64'(ifa.mismatch), 64'(tbl[i].mm));
            check("A_fail_idx", 64'(ifa.fail_idx), 64'(tbl[i].fidx));
        end

        // abort B mid-run at vec_cnt=3 with an asynchronous reset
        ifb.start = 1'b1;
        @(posedge clk); @(negedge clk);
        ifb.start = 1'b0;
        begin
            int n;
            n = 0;
            while (ifb.vec_cnt != 32'd3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("B_reach_cnt3", 64'(ifb.vec_cnt), 64'd3);
        end
        #2 rst_n = 1'b0;
        #1;
        check("RST_A_wires", 64'({ifa.wire3, ifa.wire2, ifa.wire1, ifa.wire0}), 64'd0);
        check("RST_A_status", 64'({ifa.busy, ifa.done, ifa.mismatch}), 64'd0);
        check("RST_A_vec_cnt", 64'(ifa.vec_cnt), 64'd0);
        check("RST_B_wires", 64'({ifb.wire3, ifb.wire2, ifb.wire1, ifb.wire0}), 64'd0);
        check("RST_B_status", 64'({ifb.busy, ifb.done, ifb.mismatch}), 64'd0);
        check("RST_B_vec_cnt", 64'(ifb.vec_cnt), 64'd0);
        check("RST_B_fail_idx", 64'(ifb.fail_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // B: replay from seed, then randomized miscompare runs against the model
        for (int r = 0; r < 6; r++) begin
            logic exp_mm;
            int   exp_fi;
            exp_mm = 1'b0;
            exp_fi = 0;
            for (int c = 0; c <= NB + LB + 2; c++) begin
                logic f;
                int   k;
                f  = (r > 0) && ($urandom_range(0, 4) == 0);
                yr = rand_y();
                ifb.start = (c == 0);
                ifb.y_1   = yr;
                ifb.y_2   = f ? (yr ^ {yr[0], yr[YW-1:1]} ^ flip_one) : yr;
                if (f && (yr ^ {yr[0], yr[YW-1:1]} ^ flip_one) == '0) ifb.y_2 = ~yr;
                @(posedge clk);
                @(negedge clk);
                ifb.start = 1'b0;
                k = c - 1 - LB;
                if (f && k >= 0 && k < NB && !exp_mm) begin
                    exp_mm = 1'b1;
                    exp_fi = k;
                end
                check("B_wires", 64'({ifb.wire3, ifb.wire2, ifb.wire1, ifb.wire0}),
                      64'(vec_of(SEED_B, (c < NB) ? c : NB - 1)));
                check("B_busy", 64'(ifb.busy), 64'(c <= NB + LB));
                check("B_done", 64'(ifb.done), 64'(c >= NB + LB + 1));
                check("B_vec_cnt", 64'(ifb.vec_cnt), 64'((c + 1 < NB) ? c + 1 : NB));
                check("B_mismatch", 64'(ifb.mismatch), 64'(exp_mm));
                if (exp_mm) check("B_fail_idx", 64'(ifb.fail_idx), 64'(exp_fi));
            end
        end

        // C: latency 0, zero seed; D: latency 3, flip on a non-compare then the compare edge
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 8; c++) begin
                yr = rand_y();
                ifc.start = (c == 0);
                ifd.start = (c == 0);
                ifc.y_1 = yr;
                ifd.y_1 = yr;
                ifc.y_2 = (j == 0 && c == 1) ? (yr ^ flip_one) : yr;
                ifd.y_2 = (c == ((j == 0) ? 3 : 4)) ? (yr ^ flip_one) : yr;
                @(posedge clk);
                @(negedge clk);
                ifc.start = 1'b0;
                ifd.start = 1'b0;
                check("C_wires", 64'({ifc.wire3, ifc.wire2, ifc.wire1, ifc.wire0}), 64'(vec_of(SEED_C, 0)));
                check("C_busy", 64'(ifc.busy), 64'(c <= 1));
                check("C_done", 64'(ifc.done), 64'(c >= 2));
                check("C_mismatch", 64'(ifc.mismatch), 64'(j == 0 && c >= 1));
                check("D_wires", 64'({ifd.wire3, ifd.wire2, ifd.wire1, ifd.wire0}), 64'(vec_of(SEED_D, 0)));
                check("D_busy", 64'(ifd.busy), 64'(c <= 4));
                check("D_done", 64'(ifd.done), 64'(c >= 5));
                check("D_mismatch", 64'(ifd.mismatch), 64'(j == 1 && c >= 4));
            end
            check("C_fail_idx", 64'(ifc.fail_idx), 64'd0);
            check("D_fail_idx", 64'(ifd.fail_idx), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
